// File: rtl/rx_ring_ctrl.sv
// Frame controller for the RX ring RAM: writes frames into a circular buffer, commits them on the last beat,
// rolls back errored or overflowing frames, and streams committed words out through a 2-entry skid.
module rx_ring_ctrl #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned BE_WIDTH   = 6,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   input  logic                  s_err,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic [CNT_WIDTH-1:0]  drop_cnt,
   output logic                  ovf
);
   localparam int unsigned PTR_W = ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DISCARD} wr_state_e;

   wr_state_e             wr_state_q;
   logic [PTR_W-1:0]      wr_ptr_q, commit_ptr_q, rd_ptr_q;
   logic                  s_ready_q, ovf_q, m_valid_q;
   logic [CNT_WIDTH-1:0]  frame_cnt_q, drop_cnt_q;
   logic [DEPTH-1:0]      last_mem_q;
   logic                  rd_inflight_q, rd_last_q;
   logic [1:0]            skid_cnt_q, skid_cnt_d;
   logic [DATA_WIDTH-1:0] skid0_data_q, skid0_data_d, skid1_data_q, skid1_data_d;
   logic                  skid0_last_q, skid0_last_d, skid1_last_q, skid1_last_d;

   logic       acc, full, wr_ok, pend, pop, issue;
   logic [1:0] occ;

   always_comb begin
      acc   = s_valid & s_ready_q;
      full  = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
      wr_ok = acc & ~full & (wr_state_q != WR_DISCARD);
      pend  = commit_ptr_q != rd_ptr_q;
      pop   = m_valid_q & m_ready;
      // Occupancy counts the word leaving this cycle as gone, so reads stream back to back.
      occ   = skid_cnt_q - 2'(pop) + 2'(rd_inflight_q);
      issue = pend & (occ < 2'd2);
   end

   // Skid update: pop shifts entry 1 forward, returning read data fills the first free slot.
   always_comb begin
      skid0_data_d = skid0_data_q;
      skid0_last_d = skid0_last_q;
      skid1_data_d = skid1_data_q;
      skid1_last_d = skid1_last_q;
      skid_cnt_d   = skid_cnt_q;
      if (pop) begin
         skid0_data_d = skid1_data_q;
         skid0_last_d = skid1_last_q;
         skid_cnt_d   = skid_cnt_q - 2'd1;
      end
      if (rd_inflight_q) begin
         if (skid_cnt_d == 2'd0) begin
            skid0_data_d = ram_rd_data;
            skid0_last_d = rd_last_q;
         end else begin
            skid1_data_d = ram_rd_data;
            skid1_last_d = rd_last_q;
         end
         skid_cnt_d = skid_cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_q    <= WR_IDLE;
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rd_ptr_q      <= '0;
         s_ready_q     <= 1'b0;
         ovf_q         <= 1'b0;
         m_valid_q     <= 1'b0;
         frame_cnt_q   <= '0;
         drop_cnt_q    <= '0;
         rd_inflight_q <= 1'b0;
         rd_last_q     <= 1'b0;
         skid_cnt_q    <= '0;
         skid0_data_q  <= '0;
         skid0_last_q  <= 1'b0;
         skid1_data_q  <= '0;
         skid1_last_q  <= 1'b0;
      end else begin
         s_ready_q     <= 1'b1;
         ovf_q         <= 1'b0;
         rd_inflight_q <= issue;
         if (issue) begin
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            rd_last_q <= last_mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
         end
         skid_cnt_q   <= skid_cnt_d;
         m_valid_q    <= skid_cnt_d != 2'd0;
         skid0_data_q <= skid0_data_d;
         skid0_last_q <= skid0_last_d;
         skid1_data_q <= skid1_data_d;
         skid1_last_q <= skid1_last_d;

         if (acc) begin
            case (wr_state_q)
               WR_IDLE, WR_WRITE: begin
                  if (full) begin
                     wr_ptr_q   <= commit_ptr_q;
                     drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
                     ovf_q      <= 1'b1;
                     wr_state_q <= s_last ? WR_IDLE : WR_DISCARD;
                  end else if (s_last && !s_err) begin
                     wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
                     commit_ptr_q <= wr_ptr_q + PTR_W'(1);
                     frame_cnt_q  <= frame_cnt_q + CNT_WIDTH'(1);
                     wr_state_q   <= WR_IDLE;
                  end else if (s_last) begin
                     wr_ptr_q   <= commit_ptr_q;
                     drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
                     wr_state_q <= WR_IDLE;
                  end else begin
                     wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                     wr_state_q <= WR_WRITE;
                  end
               end
               WR_DISCARD: begin
                  if (s_last) wr_state_q <= WR_IDLE;
               end
               default: wr_state_q <= WR_IDLE;
            endcase
         end
      end
   end

   // Frame-end marks travel beside the RAM data; stale bits are always rewritten before being read.
   always_ff @(posedge clk) begin
      if (wr_ok) last_mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_last;
   end

   assign s_ready        = s_ready_q;
   assign m_valid        = m_valid_q;
   assign m_data         = skid0_data_q;
   assign m_last         = skid0_last_q;
   assign ram_wr_en      = wr_ok;
   assign ram_wr_addr    = wr_ptr_q[ADDR_WIDTH-1:0];
   assign ram_wr_data    = s_data;
   assign ram_wr_byte_en = '1;
   assign ram_rd_addr    = rd_ptr_q[ADDR_WIDTH-1:0];
   assign level          = commit_ptr_q - rd_ptr_q;
   assign frame_cnt      = frame_cnt_q;
   assign drop_cnt       = drop_cnt_q;
   assign ovf            = ovf_q;

endmodule

// File: tb/tb_rx_ring_ctrl.sv
// Bench for rx_ring_ctrl: RAM model, frame-level reference (queue of committed words plus free-space arithmetic).
module tb_rx_ring_ctrl;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 48;
   localparam int unsigned BW    = 6;
   localparam int unsigned CW    = 16;
   localparam int          DEPTH = 32;

   logic          clk, rst_n;
   logic [DW-1:0] s_data, m_data, ram_wr_data, ram_rd_data;
   logic          s_valid, s_last, s_err, s_ready, m_valid, m_last, m_ready, ram_wr_en, ovf;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [BW-1:0] ram_wr_byte_en;
   logic [AW:0]   level;
   logic [CW-1:0] frame_cnt, drop_cnt;

   rx_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_err(s_err),
      .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .level(level), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .ovf(ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple dual-port RAM with byte enables and a one-cycle read.
   logic [DW-1:0] ram_q [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_en)
         for (int b = 0; b < BW; b++)
            if (ram_wr_byte_en[b]) ram_q[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
      ram_rd_data <= ram_q[ram_rd_addr];
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   exp_q[$];
   int            commit_tot = 0;
   int            taken = 0;
   int            frame_exp = 0;
   int            drop_exp = 0;
   int            rdy_mode = 0;
   int            pat_cnt = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Words the read side has fetched once it has settled with the consumer stalled.
   function automatic int rd_settled();
      int avail;
      avail = commit_tot - taken;
      return taken + ((avail < 2) ? avail : 2);
   endfunction

   task automatic check_out();
      logic [DW:0] e;
      if (prev_stall) begin
         chk("hold_valid", 64'(m_valid), 64'd1);
         chk("hold_data", 64'(m_data), 64'(prev_data));
         chk("hold_last", 64'(m_last), 64'(prev_last));
      end
      case (rdy_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         2:       m_ready = 1'($urandom % 2);
         default: m_ready = (pat_cnt % 3) == 0;
      endcase
      pat_cnt++;
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("unexpected_word", 64'(m_valid), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("m_data", 64'(m_data), 64'(e[DW-1:0]));
            chk("m_last", 64'(m_last), 64'(e[DW]));
            taken++;
         end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic send_frame(input int len, input bit err);
      logic [DW-1:0] words[$];
      logic [DW-1:0] d;
      int k;
      k = (rdy_mode == 0) ? DEPTH - (commit_tot - rd_settled()) + 1 : 1 << 20;
      for (int i = 1; i <= len; i++) begin
         d = {16'($urandom), 32'($urandom)};
         words.push_back(d);
         s_valid = 1'b1;
         s_data  = d;
         s_last  = (i == len);
         s_err   = err && (i == len);
         #1;
         if (i == 1) chk("wr_data", 64'(ram_wr_data), 64'(d));
         tick();
         chk("ovf", 64'(ovf), 64'(i == k));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_err   = 1'b0;
      if (len >= k || err) drop_exp++;
      else begin
         for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, words[i]});
         frame_exp++;
         commit_tot += len;
      end
      chk("frame_cnt", 64'(frame_cnt), 64'(CW'(frame_exp)));
      chk("drop_cnt", 64'(drop_cnt), 64'(CW'(drop_exp)));
      if (rdy_mode == 0) begin
         repeat (4) tick();
         chk("level", 64'(level), 64'(commit_tot - rd_settled()));
      end
   endtask

   task automatic drain(input int mode);
      int budget;
      budget = 600;
      rdy_mode = mode;
      while (exp_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      rdy_mode = 0;
      repeat (4) tick();
      chk("drained_valid", 64'(m_valid), 64'd0);
      chk("drained_level", 64'(level), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_err = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (3) tick();
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("s_ready_up", 64'(s_ready), 64'd1);

      // Reset in the middle of a frame loses it without counting it.
      s_valid = 1'b1; s_data = 48'h1234;
      repeat (2) tick();
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst2_s_ready", 64'(s_ready), 64'd0);
      chk("rst2_m_valid", 64'(m_valid), 64'd0);
      chk("rst2_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst2_drop_cnt", 64'(drop_cnt), 64'd0);
      chk("rst2_level", 64'(level), 64'd0);
      chk("rst2_m_data", 64'(m_data), 64'd0);
      chk("rst2_ovf", 64'(ovf), 64'd0);
      chk("rst2_wr_en", 64'(ram_wr_en), 64'd0);
      rst_n = 1'b1; s_valid = 1'b0;
      tick();
      chk("rst2_s_ready_up", 64'(s_ready), 64'd1);
      chk("byte_en", 64'(ram_wr_byte_en), 64'h3f);

      // Four-beat frame: first word two edges after the last beat, then one word per cycle.
      rdy_mode = 1;
      send_frame(4, 1'b0);
      chk("lat_e0", 64'(m_valid), 64'd0);
      tick();
      chk("lat_e1", 64'(m_valid), 64'd0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("stream_valid", 64'(m_valid), 64'd1);
         chk("stream_last", 64'(m_last), 64'(j == 3));
      end
      drain(1);

      // Errored frame is rolled back, following frame comes through intact.
      rdy_mode = 1;
      send_frame(3, 1'b1);
      repeat (3) tick();
      chk("err_level", 64'(level), 64'd0);
      chk("err_m_valid", 64'(m_valid), 64'd0);
      send_frame(2, 1'b0);
      drain(1);

      // Stalled consumer: committed frame fills the ring, second frame overflows and is dropped.
      rdy_mode = 0;
      send_frame(20, 1'b0);
      send_frame(20, 1'b0);
      drain(1);

      // Exactly full ring drained with a 1,0,0 ready pattern.
      pat_cnt = 0;
      send_frame(32, 1'b0);
      drain(3);

      // Back-to-back frames with pointer wrap while streaming.
      rdy_mode = 1;
      for (int f = 0; f < 10; f++) send_frame(7, 1'b0);
      drain(1);
      chk("wrap_frames", 64'(frame_cnt), 64'(CW'(frame_exp)));

      // Randomized phases: stalled writes with random lengths and errors, then random-ready drain.
      for (int p = 0; p < 8; p++) begin
         rdy_mode = 0;
         repeat (2 + $urandom % 4) send_frame(1 + int'($urandom % 40), ($urandom % 5) == 0);
         drain(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
